// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int   WORD_BYTES = 4;
    localparam logic PORT_CORE  = 1'b0;
    localparam logic PORT_DBG   = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin arbiter; the last-grant register moves only when a grant is taken.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_reg;

    // Reset to "port 1 granted last" so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (advance) begin
            last_reg <= gnt[1];
        end
    end

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = last_reg ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_data_arbiter.sv
// Shares a single-port data memory between the core (port 0) and debug/loader (port 1),
// one word request in flight at a time: accept, memory access, response.
module mem_data_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    input  logic              i_req0_we,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wdata,
    output logic              o_req0_ready,
    output logic              o_rsp0_valid,
    output logic [DATA_W-1:0] o_rsp0_rdata,
    output logic              o_rsp0_err,
    input  logic              i_req1_valid,
    input  logic              i_req1_we,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    output logic              o_req1_ready,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp1_rdata,
    output logic              o_rsp1_err,
    output logic              o_mem_clk_enable,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_t            state_reg, state_next;
    logic              we_reg, id_reg, err_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg, rdata_reg;

    logic [1:0]        req, gnt;
    logic              accept, sel, sel_we, sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req = {i_req1_valid, i_req0_valid};

    rr_arbiter_2 u_rr (
        .clk     (i_clk),
        .rst     (i_rst),
        .req     (req),
        .advance (accept),
        .gnt     (gnt)
    );

    assign sel       = gnt[1];
    assign sel_we    = sel ? i_req1_we    : i_req0_we;
    assign sel_addr  = sel ? i_req1_addr  : i_req0_addr;
    assign sel_wdata = sel ? i_req1_wdata : i_req0_wdata;
    assign sel_err   = (sel_addr[1:0] != 2'b00) ||
                       (sel_addr > ADDR_W'(MEM_BYTES - WORD_BYTES));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        accept           = 1'b0;
        o_req0_ready     = 1'b0;
        o_req1_ready     = 1'b0;
        o_rsp0_valid     = 1'b0;
        o_rsp1_valid     = 1'b0;
        o_rsp0_rdata     = '0;
        o_rsp1_rdata     = '0;
        o_rsp0_err       = 1'b0;
        o_rsp1_err       = 1'b0;
        o_mem_clk_enable = 1'b0;
        o_mem_write      = 1'b0;
        o_mem_addr       = '0;
        o_mem_wdata      = '0;
        case (state_reg)
            ST_IDLE: begin
                // Reset also masks ready so nothing is accepted while it is held.
                if ((|req) && !i_rst) begin
                    accept       = 1'b1;
                    o_req0_ready = gnt[0];
                    o_req1_ready = gnt[1];
                    state_next   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                o_mem_addr       = addr_reg;
                o_mem_clk_enable = !err_reg;
                o_mem_write      = we_reg && !err_reg;
                o_mem_wdata      = (we_reg && !err_reg) ? wdata_reg : '0;
                state_next       = ST_RESP;
            end
            ST_RESP: begin
                if (id_reg == PORT_DBG) begin
                    o_rsp1_valid = 1'b1;
                    o_rsp1_rdata = rdata_reg;
                    o_rsp1_err   = err_reg;
                end else begin
                    o_rsp0_valid = 1'b1;
                    o_rsp0_rdata = rdata_reg;
                    o_rsp0_err   = err_reg;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            we_reg    <= 1'b0;
            id_reg    <= PORT_CORE;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else if (accept) begin
            we_reg    <= sel_we;
            id_reg    <= sel;
            err_reg   <= sel_err;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
        end else if (state_reg == ST_ACCESS) begin
            rdata_reg <= (!we_reg && !err_reg) ? i_mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed plus randomized bench for mem_data_arbiter with a transaction-level reference model.
module tb_mem_data_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_clk_enable, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0] env_mem [0:127];
    logic [7:0] model_mem [0:127];
    logic       mem_init;
    int         model_last;

    always #5 clk = ~clk;

    mem_data_arbiter dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req0_valid     (req0_valid),
        .i_req0_we        (req0_we),
        .i_req0_addr      (req0_addr),
        .i_req0_wdata     (req0_wdata),
        .o_req0_ready     (req0_ready),
        .o_rsp0_valid     (rsp0_valid),
        .o_rsp0_rdata     (rsp0_rdata),
        .o_rsp0_err       (rsp0_err),
        .i_req1_valid     (req1_valid),
        .i_req1_we        (req1_we),
        .i_req1_addr      (req1_addr),
        .i_req1_wdata     (req1_wdata),
        .o_req1_ready     (req1_ready),
        .o_rsp1_valid     (rsp1_valid),
        .o_rsp1_rdata     (rsp1_rdata),
        .o_rsp1_err       (rsp1_err),
        .o_mem_clk_enable (mem_clk_enable),
        .o_mem_write      (mem_write),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .i_mem_rdata      (mem_rdata)
    );

    // Behavioural memory seen by the DUT: combinational read, clocked write.
    always_comb begin
        mem_rdata = '0;
        if (mem_addr <= 32'd124) begin
            mem_rdata = {env_mem[mem_addr + 3], env_mem[mem_addr + 2],
                         env_mem[mem_addr + 1], env_mem[mem_addr]};
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) env_mem[i] <= 8'(i);
        end else if (mem_clk_enable && mem_write && mem_addr <= 32'd124) begin
            env_mem[mem_addr]     <= mem_wdata[7:0];
            env_mem[mem_addr + 1] <= mem_wdata[15:8];
            env_mem[mem_addr + 2] <= mem_wdata[23:16];
            env_mem[mem_addr + 3] <= mem_wdata[31:24];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_txn(input bit v0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                          input bit v1, input bit we1, input logic [31:0] a1, input logic [31:0] d1);
        int          p;
        bit          w, e;
        logic [31:0] a, d, exp_rd;
        if (v0 && v1) p = (model_last == 1) ? 0 : 1;
        else          p = v1 ? 1 : 0;
        model_last = p;
        w = (p == 1) ? we1 : we0;
        a = (p == 1) ? a1 : a0;
        d = (p == 1) ? d1 : d0;
        e = (a % 4 != 0) || (a > 32'd124);
        exp_rd = '0;
        if (!e && !w) begin
            exp_rd = {model_mem[a + 3], model_mem[a + 2], model_mem[a + 1], model_mem[a]};
        end else if (!e && w) begin
            model_mem[a]     = d[7:0];
            model_mem[a + 1] = d[15:8];
            model_mem[a + 2] = d[23:16];
            model_mem[a + 3] = d[31:24];
        end

        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        #1;
        chk("ready0_at_t", 32'(req0_ready), 32'(p == 0));
        chk("ready1_at_t", 32'(req1_ready), 32'(p == 1));

        @(posedge clk); @(negedge clk);
        // Scramble the accepted port's fields; the DUT must use its latched copy.
        if (p == 0) begin
            req0_valid = 1'b0; req0_we = 1'($urandom); req0_addr = $urandom; req0_wdata = $urandom;
        end else begin
            req1_valid = 1'b0; req1_we = 1'($urandom); req1_addr = $urandom; req1_wdata = $urandom;
        end
        #1;
        chk("ready_in_access", 32'({req1_ready, req0_ready}), 32'd0);
        chk("mem_clk_enable", 32'(mem_clk_enable), 32'(!e));
        chk("mem_write", 32'(mem_write), 32'(w && !e));
        chk("mem_addr", mem_addr, a);
        if (w && !e) chk("mem_wdata", mem_wdata, d);

        @(posedge clk); @(negedge clk);
        #1;
        chk("rsp0_valid", 32'(rsp0_valid), 32'(p == 0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(p == 1));
        chk("rsp_rdata", (p == 1) ? rsp1_rdata : rsp0_rdata, exp_rd);
        chk("rsp_err", 32'((p == 1) ? rsp1_err : rsp0_err), 32'(e));
        chk("mem_idle_in_resp", 32'({mem_clk_enable, mem_write}), 32'd0);
        $display("txn port=%0d we=%0d addr=%h err=%0d rdata=%h", p, w, a, e, exp_rd);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [31:0] ra0, ra1;
        for (int i = 0; i < 128; i++) model_mem[i] = 8'(i);
        model_last = 1;
        mem_init = 1'b1;
        rst = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h4; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0;    req1_wdata = '0;

        // Reset: valid held, yet nothing is accepted and all outputs stay low.
        repeat (3) @(negedge clk);
        chk("reset_ready0", 32'(req0_ready), 32'd0);
        chk("reset_outputs", 32'({rsp0_valid, rsp1_valid, mem_clk_enable, mem_write}), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        mem_init = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);

        do_txn(1, 0, 32'h04, 32'h0, 0, 0, 32'h0, 32'h0);
        do_txn(0, 0, 32'h0, 32'h0, 1, 1, 32'h30, 32'hDEADBEEF);
        do_txn(0, 0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h0);
        for (int k = 0; k < 4; k++) begin
            do_txn(1, 0, 32'h30, 32'h0, 1, 0, 32'h10, 32'h0);
        end
        do_txn(1, 1, 32'h7D, 32'h12345678, 0, 0, 32'h0, 32'h0);
        do_txn(1, 1, 32'h80, 32'h12345678, 0, 0, 32'h0, 32'h0);
        do_txn(1, 1, 32'h7C, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0);
        do_txn(1, 0, 32'h7C, 32'h0, 0, 0, 32'h0, 32'h0);

        // Reset lands in ACCESS of a write: strobe drops at once, no response, write lost.
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h40; req0_wdata = 32'h11223344;
        #1;
        chk("abort_ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("abort_write_before", 32'(mem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_write_dropped", 32'({mem_write, mem_clk_enable}), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        req0_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'({rsp0_valid, rsp1_valid, req0_ready}), 32'd0);
        end
        rst = 1'b0;
        model_last = 1;
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_no_rsp_after", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        @(negedge clk);
        do_txn(1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 24; k++) begin
            r   = int'($urandom_range(1, 3));
            ra0 = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 31)) * 4;
            ra1 = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 31)) * 4;
            do_txn(r % 2 == 1, 1'($urandom), ra0, $urandom,
                   r >= 2, 1'($urandom), ra1, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
